// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among N_REQ requesters.
// Each grant lasts up to MAX_BURST writes; full stalls the owner without rotating priority.
module fifo_wr_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned D_WIDTH   = 8,
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned IDX_W     = 2
) (
  input  logic                       w_clk,
  input  logic                       w_rstn,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*D_WIDTH-1:0]   req_data,
  input  logic                       full,
  output logic [N_REQ-1:0]           ack,
  output logic                       w_inc,
  output logic [D_WIDTH-1:0]         w_data,
  output logic [IDX_W-1:0]           owner,
  output logic                       busy
);

  localparam int unsigned      CNT_W    = $clog2(MAX_BURST) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

  typedef enum logic {IDLE, GRANT} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [IDX_W-1:0]   sel_idx;
  logic [IDX_W-1:0]   cand;
  logic               sel_found;
  logic               wr;
  logic [D_WIDTH-1:0] lane [N_REQ];

  always_ff @(posedge w_clk or negedge w_rstn) begin
    if (!w_rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IDX_LAST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // First requester at or after last+1, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDX_W'((32'(last_q) + k) % N_REQ);
      if (!sel_found && req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++) begin
      lane[i] = req_data[i*D_WIDTH +: D_WIDTH];
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    wr      = (state_q == GRANT) && req[owner_q] && !full;

    unique case (state_q)
      IDLE: begin
        if (|req) begin
          owner_d = sel_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        // Withdrawal and burst completion both release the grant.
        if (!req[owner_q] || (wr && cnt_q == CNT_LAST)) begin
          state_d = IDLE;
          last_d  = owner_q;
        end else if (wr) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign w_inc  = wr;
  assign ack    = wr ? (N_REQ'(1) << owner_q) : '0;
  assign w_data = lane[owner_q];
  assign owner  = owner_q;
  assign busy   = (state_q == GRANT);

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed plus randomized checks of fifo_wr_arbiter against a cycle-level reference model.
module tb_fifo_wr_arbiter;

  localparam int unsigned N_REQ     = 4;
  localparam int unsigned D_WIDTH   = 8;
  localparam int unsigned MAX_BURST = 4;
  localparam int unsigned IDX_W     = 2;

  logic                     w_clk;
  logic                     w_rstn;
  logic [N_REQ-1:0]         req;
  logic [N_REQ*D_WIDTH-1:0] req_data;
  logic                     full;
  logic [N_REQ-1:0]         ack;
  logic                     w_inc;
  logic [D_WIDTH-1:0]       w_data;
  logic [IDX_W-1:0]         owner;
  logic                     busy;

  int n_vec;
  int n_err;

  // Reference model: who holds the grant, how many words it has written, who went last.
  bit m_busy;
  int m_owner;
  int m_last;
  int m_written;

  int obs_own[$];
  int obs_dat[$];

  fifo_wr_arbiter #(
    .N_REQ(N_REQ), .D_WIDTH(D_WIDTH), .MAX_BURST(MAX_BURST), .IDX_W(IDX_W)
  ) dut (
    .w_clk(w_clk), .w_rstn(w_rstn), .req(req), .req_data(req_data), .full(full),
    .ack(ack), .w_inc(w_inc), .w_data(w_data), .owner(owner), .busy(busy)
  );

  initial w_clk = 1'b0;
  always #5 w_clk = ~w_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int last, input logic [N_REQ-1:0] r);
    for (int d = 1; d <= N_REQ; d++) begin
      int i;
      i = (last + d) % N_REQ;
      if (r[i]) return i;
    end
    return last;
  endfunction

  task automatic model_reset();
    m_busy    = 1'b0;
    m_owner   = 0;
    m_last    = N_REQ - 1;
    m_written = 0;
  endtask

  // One cycle: drive after the falling edge, check mid-cycle, advance model at the rising edge.
  task automatic step(input logic [N_REQ-1:0] r, input logic f, input logic rn);
    bit wr;
    int exp_ack;
    int exp_dat;
    req    = r;
    full   = f;
    w_rstn = rn;
    if (!rn) model_reset();
    #1;
    wr      = m_busy && r[m_owner] && !f;
    exp_ack = wr ? (1 << m_owner) : 0;
    exp_dat = int'((req_data >> (m_owner * D_WIDTH)) & 32'hFF);
    chk("busy",  32'(busy),  32'(m_busy));
    chk("owner", 32'(owner), 32'(m_owner));
    chk("w_inc", 32'(w_inc), 32'(wr));
    chk("ack",   32'(ack),   32'(exp_ack));
    if (m_busy) chk("w_data", 32'(w_data), 32'(exp_dat));
    if (w_inc === 1'b1) begin
      obs_own.push_back(int'(owner));
      obs_dat.push_back(int'(w_data));
    end
    @(posedge w_clk);
    if (rn) begin
      if (!m_busy) begin
        if (r != '0) begin
          m_owner   = pick(m_last, r);
          m_written = 0;
          m_busy    = 1'b1;
        end
      end else if (!r[m_owner]) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end else if (wr) begin
        m_written++;
        if (m_written == MAX_BURST) begin
          m_busy = 1'b0;
          m_last = m_owner;
        end
      end
    end
    @(negedge w_clk);
  endtask

  task automatic do_reset();
    step('0, 1'b0, 1'b0);
    step('0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [N_REQ-1:0] rr;
    n_vec    = 0;
    n_err    = 0;
    w_rstn   = 1'b0;
    req      = '0;
    full     = 1'b0;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    model_reset();
    @(negedge w_clk);

    // Reset held with all requests up, then first grant goes to 0.
    for (int i = 0; i < 3; i++) step(4'b1111, 1'b0, 1'b0);
    chk("t1_rst_owner", 32'(owner), 32'd0);
    chk("t1_rst_winc",  32'(w_inc), 32'd0);
    obs_own.delete();
    step(4'b1111, 1'b0, 1'b1);
    chk("t1_first_owner", 32'(owner), 32'd0);
    chk("t1_first_busy",  32'(busy),  32'd1);

    // Round-robin with bubbles: 0,1,2,3,0 four writes each.
    for (int i = 0; i < 24; i++) step(4'b1111, 1'b0, 1'b1);
    chk("t2_count", 32'(obs_own.size()), 32'd20);
    for (int k = 0; k < 20; k++)
      chk("t2_order", (obs_own.size() > k) ? 32'(obs_own[k]) : 32'hFFFF_FFFF, 32'((k / 4) % 4));

    // Full stall mid-burst on owner 2.
    do_reset();
    step(4'b0100, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    obs_own.delete();
    for (int i = 0; i < 5; i++) step(4'b1111, 1'b1, 1'b1);
    chk("t3_stall_writes", 32'(obs_own.size()), 32'd0);
    chk("t3_stall_owner",  32'(owner), 32'd2);
    step(4'b1111, 1'b0, 1'b1);
    step(4'b1111, 1'b0, 1'b1);
    chk("t3_resume_writes", 32'(obs_own.size()), 32'd2);
    chk("t3_idle_after", 32'(busy), 32'd0);
    step(4'b1111, 1'b0, 1'b1);
    chk("t3_rotate", 32'(owner), 32'd3);

    // Withdraw after one word, then wrap scan picks 3.
    do_reset();
    step(4'b0010, 1'b0, 1'b1);
    step(4'b0010, 1'b0, 1'b1);
    step(4'b1001, 1'b0, 1'b1);
    chk("t4_idle", 32'(busy), 32'd0);
    step(4'b1001, 1'b0, 1'b1);
    chk("t4_wrap_owner", 32'(owner), 32'd3);

    // Data path: single requester on lane 2, regranted after a full burst.
    do_reset();
    obs_dat.delete();
    for (int i = 0; i < 6; i++) step(4'b0100, 1'b0, 1'b1);
    chk("t5_words", 32'(obs_dat.size()), 32'(MAX_BURST));
    for (int k = 0; k < int'(MAX_BURST); k++)
      chk("t5_data", (obs_dat.size() > k) ? 32'(obs_dat[k]) : 32'hFFFF_FFFF, 32'hA2);
    chk("t5_regrant", 32'(owner), 32'd2);

    // Async reset mid-burst on owner 3, then scan restarts at 0.
    do_reset();
    step(4'b1000, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b1);
    step(4'b1000, 1'b0, 1'b1);
    w_rstn = 1'b0;
    #1;
    chk("t6_winc_drop", 32'(w_inc), 32'd0);
    chk("t6_ack_drop",  32'(ack),   32'd0);
    step(4'b1000, 1'b0, 1'b0);
    step(4'b1111, 1'b0, 1'b1);
    chk("t6_after_owner", 32'(owner), 32'd0);

    // Randomized traffic with sticky requests, random full and occasional reset.
    rr = '0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) < 3) rr = N_REQ'($urandom_range(0, 15));
      req_data = {D_WIDTH'($urandom), D_WIDTH'($urandom), D_WIDTH'($urandom), D_WIDTH'($urandom)};
      step(rr, ($urandom_range(0, 9) < 3), ($urandom_range(0, 99) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
